// File: rtl/prism_ctr_bank.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | prism_ctr_bank: NUM_CH preloadable down-counters with sticky zero status |
// | and maskable IRQ; optional auto-reload via PRISM_CTR_AUTORELOAD_EN.      |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module prism_ctr_bank #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 27
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              halt,
  input  logic [NUM_CH-1:0] dec,
  input  logic [NUM_CH-1:0] load,
  input  logic [5:0]        address,
  input  logic [31:0]       data_in,
  input  logic [1:0]        data_write_n,
  output logic [31:0]       data_out,
  output logic [NUM_CH-1:0] zero,
  output logic              irq
);

  localparam logic [3:0] CTRL_SEL = 4'hE;
  localparam logic [3:0] STAT_SEL = 4'hF;

  logic [NUM_CH-1:0][CNT_W-1:0] count_q, count_d;
  logic [NUM_CH-1:0][CNT_W-1:0] preload_q, preload_d;
  logic [NUM_CH-1:0]            irq_en_q, irq_en_d;
  logic [NUM_CH-1:0]            status_q, status_d;
  logic [NUM_CH-1:0]            autoreload;
  logic                         wr_en, ctrl_wr, stat_wr;
  logic                         unused_bits;

  assign wr_en   = (data_write_n == 2'b10);
  assign ctrl_wr = wr_en && (address[5:2] == CTRL_SEL);
  assign stat_wr = wr_en && (address[5:2] == STAT_SEL);
  assign unused_bits = ^{data_in, address[1:0]};

`ifdef PRISM_CTR_AUTORELOAD_EN
  logic [NUM_CH-1:0] autoreload_q, autoreload_d;

  assign autoreload_d = ctrl_wr ? data_in[NUM_CH+7:8] : autoreload_q;
  assign autoreload   = autoreload_q;

  always_ff @(posedge clk) begin
    if (rst) autoreload_q <= '0;
    else     autoreload_q <= autoreload_d;
  end
`else
  assign autoreload = '0;
`endif

  always_comb begin
    count_d   = count_q;
    preload_d = preload_q;
    irq_en_d  = ctrl_wr ? data_in[NUM_CH-1:0] : irq_en_q;
    status_d  = stat_wr ? (status_q & ~data_in[NUM_CH-1:0]) : status_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_en && (address[5:3] == 3'(i)) && !address[2])
        preload_d[i] = data_in[CNT_W-1:0];
      if (wr_en && (address[5:3] == 3'(i)) && address[2])
        count_d[i] = data_in[CNT_W-1:0];
      else if (load[i] && enable && !halt)
        count_d[i] = preload_q[i];
      else if (dec[i] && !halt && (count_q[i] != '0)) begin
        count_d[i] = count_q[i] - CNT_W'(1);
        // Only a decrement landing on zero is an event; the set overrides a same-cycle W1C.
        if (count_q[i] == CNT_W'(1)) status_d[i] = 1'b1;
      end
`ifdef PRISM_CTR_AUTORELOAD_EN
      else if (dec[i] && !halt && autoreload[i] && enable)
        count_d[i] = preload_q[i];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      preload_q <= '0;
      irq_en_q  <= '0;
      status_q  <= '0;
    end else begin
      count_q   <= count_d;
      preload_q <= preload_d;
      irq_en_q  <= irq_en_d;
      status_q  <= status_d;
    end
  end

  always_comb begin
    data_out = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (address[5:3] == 3'(i))
        data_out[CNT_W-1:0] = address[2] ? count_q[i] : preload_q[i];
    end
    if (address[5:2] == CTRL_SEL) begin
      data_out[NUM_CH-1:0]  = irq_en_q;
      data_out[NUM_CH+7:8]  = autoreload;
    end
    if (address[5:2] == STAT_SEL)
      data_out[NUM_CH-1:0] = status_q;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_zero
    assign zero[g] = (count_q[g] == '0);
  end

  assign irq = |(status_q & irq_en_q);

endmodule
`default_nettype wire

// File: tb/tb_prism_ctr_bank.sv
`default_nettype none
// Directed self-checking bench for prism_ctr_bank (default 2x27 and a 7x4 instance).
module tb_prism_ctr_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        halt = 1'b0;
  logic [1:0]  dec = '0;
  logic [1:0]  load = '0;
  logic [5:0]  address = '0;
  logic [31:0] data_in = '0;
  logic [1:0]  data_write_n = 2'b11;
  logic [31:0] data_out;
  logic [1:0]  zero;
  logic        irq;

  logic [6:0]  b_dec = '0;
  logic [6:0]  b_load = '0;
  logic [5:0]  b_address = '0;
  logic [31:0] b_data_in = '0;
  logic [1:0]  b_data_write_n = 2'b11;
  logic [31:0] b_data_out;
  logic [6:0]  b_zero;
  logic        b_irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prism_ctr_bank #(.NUM_CH(2), .CNT_W(27)) dut (
    .clk(clk), .rst(rst), .enable(enable), .halt(halt), .dec(dec), .load(load),
    .address(address), .data_in(data_in), .data_write_n(data_write_n),
    .data_out(data_out), .zero(zero), .irq(irq)
  );

  prism_ctr_bank #(.NUM_CH(7), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .halt(halt), .dec(b_dec), .load(b_load),
    .address(b_address), .data_in(b_data_in), .data_write_n(b_data_write_n),
    .data_out(b_data_out), .zero(b_zero), .irq(b_irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write is presented for exactly one edge together with whatever strobes are set.
  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    address = a; data_in = d; data_write_n = 2'b10;
    tick();
    data_write_n = 2'b11;
  endtask

  task automatic rd(input string tag, input logic [5:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(tag, data_out, exp);
  endtask

  initial begin
    logic [31:0] ar_seq [4];
    logic [31:0] ctrl_b_exp;
`ifdef PRISM_CTR_AUTORELOAD_EN
    ar_seq = '{32'd1, 32'd0, 32'd2, 32'd1};
    ctrl_b_exp = 32'h7F7F;
`else
    ar_seq = '{32'd1, 32'd0, 32'd0, 32'd0};
    ctrl_b_exp = 32'h007F;
`endif

    // Reset
    tick(); tick();
    rst = 1'b0;
    rd("rst_pre0", 6'h00, 0);
    rd("rst_cnt0", 6'h04, 0);
    rd("rst_pre1", 6'h08, 0);
    rd("rst_cnt1", 6'h0C, 0);
    rd("rst_ctrl", 6'h38, 0);
    rd("rst_stat", 6'h3C, 0);
    chk("rst_zero", 32'(zero), 32'h3);
    chk("rst_irq", 32'(irq), 0);
    rd("unimpl_ch2", 6'h10, 0);

    // Ch0 countdown with irq
    wr(6'h00, 32'd3);
    wr(6'h38, 32'h1);
    rd("pre0_rb", 6'h00, 3);
    rd("pre_no_cnt", 6'h04, 0);
    enable = 1'b1;
    load = 2'b01; tick(); load = 2'b00;
    rd("load0", 6'h04, 3);
    chk("zero_after_load", 32'(zero), 32'h2);
    dec = 2'b01;
    tick(); rd("dec0_a", 6'h04, 2);
    tick(); rd("dec0_b", 6'h04, 1);
    chk("irq_before", 32'(irq), 0);
    tick(); rd("dec0_c", 6'h04, 0);
    dec = 2'b00;
    rd("stat0_set", 6'h3C, 1);
    chk("irq_set", 32'(irq), 1);
    chk("zero_at0", 32'(zero), 32'h3);
    wr(6'h3C, 32'h1);
    chk("irq_w1c", 32'(irq), 0);
    dec = 2'b01; tick(); dec = 2'b00;
    rd("hold_at0", 6'h04, 0);
    rd("no_event_at0", 6'h3C, 0);

    // Ch1 autoreload
    wr(6'h08, 32'd2);
    wr(6'h38, 32'h201);
    rd("ctrl_ar", 6'h38, ctrl_b_exp == 32'h7F7F ? 32'h201 : 32'h1);
    load = 2'b10; tick(); load = 2'b00;
    rd("load1", 6'h0C, 2);
    dec = 2'b10;
    for (int k = 0; k < 4; k++) begin
      tick();
      rd($sformatf("ar_step%0d", k), 6'h0C, ar_seq[k]);
    end
    dec = 2'b00;
    rd("stat1_set", 6'h3C, 2);
    chk("irq_masked", 32'(irq), 0);
    wr(6'h3C, 32'h2);

    // Halt freezes strobes, bus writes still land
    wr(6'h04, 32'd4);
    wr(6'h0C, 32'd6);
    halt = 1'b1; load = 2'b11; dec = 2'b11;
    for (int k = 0; k < 5; k++) tick();
    rd("halt_c0", 6'h04, 4);
    rd("halt_c1", 6'h0C, 6);
    wr(6'h04, 32'h5);
    rd("halt_wr", 6'h04, 5);
    halt = 1'b0; load = 2'b00; dec = 2'b00;

    // Priority: COUNT write beats load and dec
    wr(6'h00, 32'd9);
    load = 2'b01; dec = 2'b01;
    wr(6'h04, 32'd7);
    load = 2'b00; dec = 2'b00;
    rd("prio_wr", 6'h04, 7);

    // Zero event vs same-cycle W1C
    wr(6'h04, 32'd1);
    dec = 2'b01;
    wr(6'h3C, 32'h1);
    dec = 2'b00;
    rd("evt_vs_w1c_cnt", 6'h04, 0);
    rd("evt_vs_w1c_stat", 6'h3C, 1);
    chk("evt_irq", 32'(irq), 1);

    // enable low gates load
    enable = 1'b0;
    load = 2'b01; tick(); load = 2'b00;
    rd("load_gated", 6'h04, 0);

    // Wide instance: width truncation and CTRL field masks
    b_address = 6'h34; b_data_in = 32'hFFFF_FFFF; b_data_write_n = 2'b10;
    tick();
    b_data_write_n = 2'b11;
    #1 chk("b_cnt6", b_data_out, 32'hF);
    chk("b_zero", 32'(b_zero), 32'h3F);
    b_address = 6'h38; b_data_write_n = 2'b10;
    tick();
    b_data_write_n = 2'b11;
    #1 chk("b_ctrl", b_data_out, ctrl_b_exp);
    chk("b_irq", 32'(b_irq), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
